// File: rtl/h80cpu_io.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// h80cpu_io : h80 I/O-space bus slave with a transmit-only 8N1 UART
// Revision  : 1.0
// ============================================================================
module h80cpu_io #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [15:0] addr,
  input  logic [2:0]  cmd,
  input  logic        run,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        uart_txp
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] CMD_READ_W  = 3'd0;
  localparam logic [2:0] CMD_WRITE_W = 3'd1;
  localparam logic [2:0] CMD_READ_B  = 3'd2;
  localparam logic [2:0] CMD_WRITE_B = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txp_q, txp_d;
  logic           done_q, done_d;
  logic [15:0]    rd_q, rd_d;

  logic        tx_busy, req, word0, tx_wr, baud_wrap;
  logic [15:0] status;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txp_d   = txp_q;
    done_d  = done_q;
    rd_d    = rd_q;

    tx_busy   = (state_q != ST_IDLE);
    status    = {15'd0, tx_busy};
    req       = (run != done_q);
    word0     = (addr[15:1] == 15'd0);
    tx_wr     = ((cmd == CMD_WRITE_W) && word0) ||
                ((cmd == CMD_WRITE_B) && word0 && !addr[0]);
    baud_wrap = (baud_q == BAUD_LAST);

    if (tx_busy) begin
      baud_d = baud_wrap ? '0 : baud_q + CW'(1);
    end

    // Shift register presents the next data bit in [0]; bits leave LSB first.
    case (state_q)
      ST_START: if (baud_wrap) begin
        state_d = ST_DATA;
        bit_d   = 3'd0;
        txp_d   = shift_q[0];
        shift_d = shift_q >> 1;
      end
      ST_DATA: if (baud_wrap) begin
        if (bit_q == 3'd7) begin
          state_d = ST_STOP;
          txp_d   = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          txp_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_STOP: if (baud_wrap) begin
        state_d = ST_IDLE;
        txp_d   = 1'b1;
      end
      default: ;
    endcase

    // A TX write that finds the transmitter busy stays pending (back-pressure).
    if (req) begin
      case (cmd)
        CMD_READ_W: begin
          rd_d   = word0 ? status : 16'd0;
          done_d = ~done_q;
        end
        CMD_READ_B: begin
          rd_d   = (word0 && !addr[0]) ? status : 16'd0;
          done_d = ~done_q;
        end
        default: begin
          if (tx_wr) begin
            if (!tx_busy) begin
              state_d = ST_START;
              baud_d  = '0;
              bit_d   = 3'd0;
              shift_d = wr_data[7:0];
              txp_d   = 1'b0;
              done_d  = ~done_q;
            end
          end else begin
            done_d = ~done_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txp_q   <= 1'b1;
      done_q  <= 1'b0;
      rd_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txp_q   <= txp_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_data  = rd_q;
  assign done     = done_q;
  assign uart_txp = txp_q;

endmodule
`default_nettype wire

// File: tb/tb_h80cpu_io.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_h80cpu_io : directed table, random requests and a frame-level line model
// Revision     : 1.0
// ============================================================================
module tb_h80cpu_io;

  localparam int B     = 16;       // 1600 Hz / 100 baud
  localparam int FRAME = 10 * B;
  localparam int DEF_B = 234;      // 27 MHz / 115200

  logic        clk = 1'b0;
  logic        reset_;
  logic [15:0] addr, wr_data, rd_data;
  logic [2:0]  cmd;
  logic        run, done, uart_txp;

  logic [15:0] addr2, wd2, rd2;
  logic [2:0]  cmd2;
  logic        run2, done2, uart2;

  always #5 clk = ~clk;

  h80cpu_io #(.CLK_FREQ(1600), .BAUD(100)) u_dut (
    .clk(clk), .reset_(reset_), .addr(addr), .cmd(cmd), .run(run),
    .wr_data(wr_data), .rd_data(rd_data), .done(done), .uart_txp(uart_txp)
  );

  h80cpu_io u_dut_def (
    .clk(clk), .reset_(reset_), .addr(addr2), .cmd(cmd2), .run(run2),
    .wr_data(wd2), .rd_data(rd2), .done(done2), .uart_txp(uart2)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_line_prints = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: list of accepted frames (acceptance edge, byte).
  int          fr_edge[$];
  logic [7:0]  fr_byte[$];
  logic [15:0] exp_rd;

  function automatic logic model_line(input int n);
    logic v;
    logic [7:0] b;
    int d, idx;
    v = 1'b1;
    for (int i = 0; i < fr_edge.size(); i++) begin
      d = n - fr_edge[i];
      if (d >= 0 && d < FRAME) begin
        idx = d / B;
        b   = fr_byte[i];
        if (idx == 0)      v = 1'b0;
        else if (idx == 9) v = 1'b1;
        else               v = b[idx-1];
      end
    end
    return v;
  endfunction

  function automatic bit model_busy(input int s);
    int e;
    if (fr_edge.size() == 0) return 1'b0;
    e = fr_edge[fr_edge.size()-1];
    return (s > e) && (s <= e + FRAME);
  endfunction

  function automatic int accept_edge(input int s);
    int e;
    if (fr_edge.size() == 0) return s;
    e = fr_edge[fr_edge.size()-1] + FRAME + 1;
    return (s > e) ? s : e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (uart_txp !== model_line(cyc)) begin
        n_bad++;
        if (n_line_prints < 20)
          $display("FAIL uart_txp: got %b expected %b (cycle %0d)", uart_txp, model_line(cyc), cyc);
        n_line_prints++;
      end
    end
  end

  task automatic do_req(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d,
                        input int gap, input bit use_tbl, input int tbl_lat,
                        input logic [15:0] tbl_rd);
    int s, lat, exp_lat;
    bit tx, busy;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    cmd = c; addr = a; wr_data = d; run = ~run;
    s    = cyc + 1;
    tx   = ((c == 3'd1) && (a[15:1] == 15'd0)) || ((c == 3'd3) && (a == 16'h0000));
    busy = model_busy(s);
    if (c == 3'd0) exp_rd = (a[15:1] == 15'd0) ? {15'd0, busy} : 16'd0;
    if (c == 3'd2) exp_rd = ((a[15:1] == 15'd0) && !a[0]) ? {15'd0, busy} : 16'd0;
    exp_lat = 1;
    if (tx) begin
      exp_lat = accept_edge(s) - s + 1;
      fr_edge.push_back(accept_edge(s));
      fr_byte.push_back(d[7:0]);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done !== run && lat < 3000);
    check("done_latency", lat, exp_lat);
    check("rd_data", rd_data, exp_rd);
    if (use_tbl) begin
      check("tbl_latency", lat, tbl_lat);
      check("tbl_rd_data", rd_data, tbl_rd);
    end
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gap;
    int          lat;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cnt;
    logic prev;
    logic [2:0] c;
    logic [15:0] a;
    int g;

    tbl[0]  = '{3'd3, 16'h0000, 16'h0041,   0,   1, 16'h0000}; // start frame 0x41
    tbl[1]  = '{3'd0, 16'h0000, 16'h0000,   4,   1, 16'h0001}; // status busy
    tbl[2]  = '{3'd1, 16'h0000, 16'h1234,   0, 156, 16'h0001}; // held until frame ends
    tbl[3]  = '{3'd0, 16'h0000, 16'h0000,   0,   1, 16'h0001};
    tbl[4]  = '{3'd0, 16'h0010, 16'h0000,   0,   1, 16'h0000};
    tbl[5]  = '{3'd1, 16'h0010, 16'hBEEF,   0,   1, 16'h0000};
    tbl[6]  = '{3'd5, 16'h0000, 16'h00C3,   0,   1, 16'h0000};
    tbl[7]  = '{3'd0, 16'h0000, 16'h0000,   0,   1, 16'h0001};
    tbl[8]  = '{3'd7, 16'h0010, 16'h0000,   0,   1, 16'h0001}; // reserved keeps rd_data
    tbl[9]  = '{3'd2, 16'h0001, 16'h0000,   0,   1, 16'h0000};
    tbl[10] = '{3'd2, 16'h0000, 16'h0000,   0,   1, 16'h0001};
    tbl[11] = '{3'd3, 16'h0001, 16'h00FF,   0,   1, 16'h0001}; // ignored, no stall
    tbl[12] = '{3'd0, 16'h0001, 16'h0000, 200,   1, 16'h0000};
    tbl[13] = '{3'd3, 16'h0000, 16'h00A5,   0,   1, 16'h0000};

    reset_ = 1'b1; run = 1'b0; cmd = 3'd0; addr = 16'd0; wr_data = 16'd0;
    run2 = 1'b0; cmd2 = 3'd0; addr2 = 16'd0; wd2 = 16'd0;
    exp_rd = 16'd0;
    #2 reset_ = 1'b0;
    #1;
    check("reset_txp", uart_txp, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_rd", rd_data, 16'h0000);
    check("reset_txp_def", uart2, 1'b1);
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 14; i++)
      do_req(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, tbl[i].gap, 1'b1, tbl[i].lat, tbl[i].rd);

    // Reset in the middle of the 0xA5 frame.
    repeat (40) @(negedge clk);
    do_req(3'd0, 16'h0000, 16'h0000, 0, 1'b1, 1, 16'h0001);
    if (run == 1'b0) do_req(3'd0, 16'h0000, 16'h0000, 0, 1'b1, 1, 16'h0001);
    @(negedge clk); #2;
    chk_en = 1'b0;
    reset_ = 1'b0;
    #1;
    check("async_txp", uart_txp, 1'b1);
    check("async_done", done, 1'b0);
    check("async_rd", rd_data, 16'h0000);
    run = 1'b0;
    fr_edge.delete(); fr_byte.delete(); exp_rd = 16'd0;
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("no_spurious_done", done, 1'b0);

    for (int i = 0; i < 60; i++) begin
      c = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 16'h0000;
        1: a = 16'h0001;
        2: a = 16'h0010;
        default: a = 16'($urandom);
      endcase
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 200) : $urandom_range(0, 3);
      do_req(c, a, 16'($urandom), g, 1'b0, 0, 16'h0000);
    end
    repeat (FRAME + 5) @(negedge clk);

    // Default parameters: 0x55 alternates every bit, so each edge-to-edge gap is one bit.
    @(negedge clk);
    cmd2 = 3'd3; addr2 = 16'h0000; wd2 = 16'h0055; run2 = 1'b1;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (done2 !== run2 && cnt < 100);
    check("def_accept_latency", cnt, 1);
    check("def_start_bit", uart2, 1'b0);
    prev = uart2;
    for (int k = 0; k < 9; k++) begin
      cnt = 0;
      do begin @(posedge clk); #1; cnt++; end while (uart2 === prev && cnt < 1000);
      check("def_bit_width", cnt, DEF_B);
      prev = uart2;
    end
    check("def_stop_level", uart2, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    check("def_idle_after", uart2, 1'b1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
